// File: rtl/uart_tx_fsm.sv
// UART transmit FSM: start bit, DATA_W data bits LSB first, optional parity,
// stop bit. Bit time is Prescale clock cycles (0 treated as 1).
// Optional feature macro: UART_TX_PARITY_EN (parity state and generator).
// Handshake: a byte is accepted on any rising edge where the FSM is idle and
// Data_Valid=1; Busy is high from that edge until the edge ending the stop
// bit, and Data_Valid is ignored while Busy is high (no queueing).
// The FSM state is held in state_q (state_e) for binding checkers.
module uart_tx_fsm #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_W-1:0]  P_DATA,
  input  logic               Data_Valid,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  output logic               TX_OUT,
  output logic               Busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [PRESC_W-1:0]  presc_max;
  logic                bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity bit is computed once when the byte is accepted, since the shift
  // register is consumed while the data bits go out.
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // Last count of the bit period; a latched Prescale of 0 behaves as 1.
  assign presc_max = (presc_q == '0) ? '0 : presc_q - PRESC_W'(1);
  assign bit_end   = (presc_cnt_q == presc_max);

  // Register all state; reset forces an idle, high line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      presc_cnt_q <= '0;
      presc_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      presc_q     <= presc_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  // Next state; tx_d/busy_d are the line values for the state being entered,
  // so the outputs stay registered with no input-to-output path.
  always_comb begin
    state_d     = state_q;
    presc_cnt_d = presc_cnt_q;
    presc_d     = presc_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif

    if (state_q != IDLE) begin
      presc_cnt_d = bit_end ? '0 : presc_cnt_q + PRESC_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          shift_d     = P_DATA;
          presc_d     = Prescale;
          presc_cnt_d = '0;
          bit_cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_en_d    = PAR_EN;
          par_bit_d   = (^P_DATA) ^ PAR_TYP;
`endif
          state_d     = START;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed testbench for uart_tx_fsm; follows the parity build via
// UART_TX_PARITY_EN.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_fsm #(.DATA_W(8), .PRESC_W(6)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .Prescale   (prescale),
    .TX_OUT     (tx_out),
    .Busy       (busy)
  );

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: present a byte for one edge, then drop Data_Valid
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] presc);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = presc;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  // Called just after the accepting edge; checks every line cycle against
  // the expected frame and the Busy length. Optionally scrambles inputs.
  task automatic capture_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                               input int n, input bit scramble, input string tag);
    logic exp_q[$];
    int   c;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe && PAR_BUILT) exp_q.push_back(exp_par);
    exp_q.push_back(1'b1);
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      if (c < exp_q.size() * n) check({tag, "_tx"}, 32'(tx_out), 32'(exp_q[c / n]));
      if (scramble) begin
        p_data   = 8'($urandom_range(0, 255));
        par_en   = 1'($urandom_range(0, 1));
        par_typ  = 1'($urandom_range(0, 1));
        prescale = 6'($urandom_range(0, 63));
      end
      c++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_len"}, 32'(c), 32'(exp_q.size() * n));
    check({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
  endtask

  // parity vectors: data, par_typ, prescale, hand-computed parity bit
  logic [7:0] pv_data [5] = '{8'h03, 8'h03, 8'h07, 8'hFF, 8'hFF};
  logic       pv_typ  [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
  logic [5:0] pv_presc[5] = '{6'd1,  6'd1,  6'd1,  6'd4,  6'd0};
  logic       pv_par  [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1};

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd1;

    // reset then idle
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_tx", 32'(tx_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      check("idle_tx", 32'(tx_out), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // basic frame, no parity: line 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5, 1'b0, 1'b0, 6'd1);
    capture_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, "a5");

    // parity frames (parity omitted when the feature is not built)
    for (int k = 0; k < 5; k++) begin
      start_frame(pv_data[k], 1'b1, pv_typ[k], pv_presc[k]);
      capture_frame(pv_data[k], 1'b1, pv_par[k],
                    (pv_presc[k] == 6'd0) ? 1 : int'(pv_presc[k]), 1'b1,
                    $sformatf("par%0d", k));
    end

    // controller-style two-byte send with Data_Valid held high
    p_data     = 8'h34;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd2;
    data_valid = 1'b1;
    @(posedge clk); #1;
    check("b1_busy_rise", 32'(busy), 32'd1);
    p_data = 8'h12;
    capture_frame(8'h34, 1'b0, 1'b0, 2, 1'b0, "b1");
    check("gap_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("b2_busy_rise", 32'(busy), 32'd1);
    data_valid = 1'b0;
    capture_frame(8'h12, 1'b0, 1'b0, 2, 1'b0, "b2");

    // reset during data bit 3 of 0x5A (prescale 2 -> cycle 8)
    start_frame(8'h5A, 1'b0, 1'b0, 6'd2);
    repeat (8) begin @(posedge clk); #1; end
    check("mid_tx", 32'(tx_out), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx", 32'(tx_out), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_tx", 32'(tx_out), 32'd1);
    end
    start_frame(8'hC3, 1'b0, 1'b0, 6'd1);
    capture_frame(8'hC3, 1'b0, 1'b0, 1, 1'b1, "c3");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
